// File: rtl/nios_noc_pkg.sv
// Shared types and constants for the NoC output doorbell: FSM states,
// register addresses and STATUS bit positions.
package nios_noc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } db_state_e;

  localparam logic [1:0] ADDR_DOORBELL = 2'd0;
  localparam logic [1:0] ADDR_TIMEOUT  = 2'd1;
  localparam logic [1:0] ADDR_MASK     = 2'd2;
  localparam logic [1:0] ADDR_STATUS   = 2'd3;

  localparam int ST_DONE = 0;
  localparam int ST_TMO  = 1;
  localparam int ST_OVF  = 2;

endpackage

// File: rtl/nios_noc_output_doorbell_if.sv
// Avalon-MM slave bus seen by the doorbell: word address, select, write
// strobe, write data and registered read data.
interface nios_noc_output_doorbell_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/noc_doorbell_fsm.sv
// Four-phase request/acknowledge engine toward the NoC peer, with a
// per-phase cycle counter compared against a programmable timeout limit.
//
// state | meaning
// IDLE  | no request outstanding; starts one when work is queued
// REQ   | out_port high, waiting for the peer to raise out_ack
// DROP  | out_port low, waiting for the peer to release out_ack
module noc_doorbell_fsm
  import nios_noc_pkg::*;
#(
  parameter int TMO_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pend_nz,
  input  logic [TMO_W-1:0] limit,
  input  logic             out_ack,
  output logic             out_port,
  output logic             busy,
  output logic             deq,
  output logic             done,
  output logic             tmo
);

  localparam logic [TMO_W-1:0] CNT_ONE = TMO_W'(1);

  db_state_e        state_q, state_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic             out_port_q;
  logic             tmo_hit;

  // A limit of zero disables the timeout entirely.
  assign tmo_hit = (limit != '0) && (cnt_q == (limit - CNT_ONE));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      out_port_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      out_port_q <= (state_d == REQ);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pend_nz) begin
          state_d = REQ;
          cnt_d   = '0;
        end
      end
      REQ: begin
        cnt_d = cnt_q + CNT_ONE;
        if (out_ack) begin
          state_d = DROP;
          cnt_d   = '0;
        end else if (tmo_hit) begin
          state_d = IDLE;
        end
      end
      DROP: begin
        cnt_d = cnt_q + CNT_ONE;
        if (!out_ack || tmo_hit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    deq  = 1'b0;
    done = 1'b0;
    tmo  = 1'b0;
    busy = (state_q != IDLE);
    case (state_q)
      IDLE: deq = pend_nz;
      REQ:  tmo = !out_ack && tmo_hit;
      DROP: begin
        done = !out_ack;
        tmo  = out_ack && tmo_hit;
      end
      default: ;
    endcase
  end

  assign out_port = out_port_q;

endmodule

// File: rtl/nios_noc_output_doorbell.sv
// Nios II doorbell toward a NoC peer: register file, saturating request
// queue counter, sticky status with maskable irq, and the handshake FSM.
module nios_noc_output_doorbell
  import nios_noc_pkg::*;
#(
  parameter int PEND_W = 4,
  parameter int TMO_W  = 16
) (
  input  logic                             clk,
  input  logic                             reset_n,
  nios_noc_output_doorbell_if.slave        avs,
  output logic                             out_port,
  input  logic                             out_ack,
  output logic                             irq
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  logic [PEND_W-1:0] pend_q;
  logic [TMO_W-1:0]  tmo_q;
  logic [2:0]        mask_q;
  logic [2:0]        status_q, status_d;
  logic [31:0]       rd_d, rd_q;

  logic wr_en, db_wr, db_accept, db_ovf;
  logic busy, deq, done_ev, tmo_ev;
  logic [2:0] st_set, st_clr;
  logic unused_wdata;

  assign wr_en     = avs.chipselect && !avs.write_n;
  assign db_wr     = wr_en && (avs.address == ADDR_DOORBELL) && avs.writedata[0];
  assign db_accept = db_wr && (pend_q != PEND_MAX);
  assign db_ovf    = db_wr && (pend_q == PEND_MAX);
  assign unused_wdata = ^avs.writedata;

  noc_doorbell_fsm #(.TMO_W(TMO_W)) u_fsm (
    .clk      (clk),
    .reset_n  (reset_n),
    .pend_nz  (pend_q != '0),
    .limit    (tmo_q),
    .out_ack  (out_ack),
    .out_port (out_port),
    .busy     (busy),
    .deq      (deq),
    .done     (done_ev),
    .tmo      (tmo_ev)
  );

  // Simultaneous enqueue and dequeue leave the count unchanged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q <= '0;
    end else begin
      case ({db_accept, deq})
        2'b10:   pend_q <= pend_q + PEND_ONE;
        2'b01:   pend_q <= pend_q - PEND_ONE;
        default: pend_q <= pend_q;
      endcase
    end
  end

  always_comb begin
    st_set          = '0;
    st_set[ST_DONE] = done_ev;
    st_set[ST_TMO]  = tmo_ev;
    st_set[ST_OVF]  = db_ovf;
    st_clr = (wr_en && (avs.address == ADDR_STATUS)) ? avs.writedata[2:0] : 3'b000;
    // Set wins over a same-cycle write-one-to-clear.
    status_d = (status_q & ~st_clr) | st_set;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_q    <= '1;
      mask_q   <= '0;
      status_q <= '0;
    end else begin
      status_q <= status_d;
      if (wr_en && (avs.address == ADDR_TIMEOUT)) tmo_q  <= avs.writedata[TMO_W-1:0];
      if (wr_en && (avs.address == ADDR_MASK))    mask_q <= avs.writedata[2:0];
    end
  end

  always_comb begin
    rd_d = '0;
    case (avs.address)
      ADDR_DOORBELL: begin
        rd_d[0]           = busy;
        rd_d[8 +: PEND_W] = pend_q;
      end
      ADDR_TIMEOUT: rd_d[TMO_W-1:0] = tmo_q;
      ADDR_MASK:    rd_d[2:0]       = mask_q;
      default:      rd_d[2:0]       = status_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_q <= '0;
    else          rd_q <= rd_d;
  end

  assign avs.readdata = rd_q;
  assign irq = |(status_q & mask_q);

endmodule

// File: tb/tb_nios_noc_output_doorbell.sv
// Randomized and directed bench for the NoC output doorbell, checked each
// cycle against a behavioural model of queue, handshake and registers.
module tb_nios_noc_output_doorbell;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic out_port, out_ack, irq;

  nios_noc_output_doorbell_if bus ();

  nios_noc_output_doorbell #(.PEND_W(4), .TMO_W(16)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .avs      (bus.slave),
    .out_port (out_port),
    .out_ack  (out_ack),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: phase 0 idle, 1 request high, 2 request dropped.
  int          m_phase, m_age, m_pend, m_status, m_mask, m_tmo;
  logic [31:0] m_rd;
  bit          m_outp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_age = 0; m_pend = 0; m_status = 0; m_mask = 0;
    m_tmo = 16'hFFFF; m_rd = '0; m_outp = 1'b0;
  endtask

  task automatic model_step();
    bit wr, deq;
    int sets, old_pend;
    wr = bus.chipselect && !bus.write_n;
    deq = 1'b0;
    sets = 0;
    old_pend = m_pend;
    case (bus.address)
      2'd0:    m_rd = 32'((m_phase != 0) ? 1 : 0) | 32'(m_pend << 8);
      2'd1:    m_rd = 32'(m_tmo);
      2'd2:    m_rd = 32'(m_mask);
      default: m_rd = 32'(m_status);
    endcase
    if (m_phase == 0) begin
      if (m_pend > 0) begin m_phase = 1; m_age = 0; deq = 1'b1; end
    end else begin
      m_age = (m_age + 1) % 65536;
      if (m_phase == 1 && out_ack) begin
        m_phase = 2; m_age = 0;
      end else if (m_phase == 2 && !out_ack) begin
        sets |= 1; m_phase = 0;
      end else if (m_tmo != 0 && m_age == m_tmo) begin
        sets |= 2; m_phase = 0;
      end
    end
    if (wr && bus.address == 2'd0 && bus.writedata[0]) begin
      if (old_pend == 15) sets |= 4;
      else m_pend = m_pend + 1;
    end
    if (deq) m_pend = m_pend - 1;
    if (wr && bus.address == 2'd3) m_status = m_status & ~int'(bus.writedata[2:0]);
    m_status = m_status | sets;
    if (wr && bus.address == 2'd1) m_tmo  = int'(bus.writedata[15:0]);
    if (wr && bus.address == 2'd2) m_mask = int'(bus.writedata[2:0]);
    m_outp = (m_phase == 1);
  endtask

  task automatic drive(input logic [1:0] a, input logic cs, input logic wn, input logic [31:0] d);
    bus.address = a; bus.chipselect = cs; bus.write_n = wn; bus.writedata = d;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("out_port", 32'(out_port), 32'(m_outp));
    chk("readdata", bus.readdata, m_rd);
    chk("irq", 32'(irq), 32'((m_status & m_mask) != 0));
  endtask

  task automatic wr_tick(input logic [1:0] a, input logic [31:0] d);
    drive(a, 1'b1, 1'b0, d);
    tick();
    drive(2'd0, 1'b0, 1'b1, 32'd0);
  endtask

  task automatic rd_tick(input logic [1:0] a);
    drive(a, 1'b1, 1'b1, 32'd0);
    tick();
    drive(2'd0, 1'b0, 1'b1, 32'd0);
  endtask

  // Peer that mirrors out_port onto out_ack; counts completed requests.
  task automatic follow_peer(input int cycles, output int falls);
    logic prev;
    falls = 0;
    for (int i = 0; i < cycles; i++) begin
      prev = out_port;
      out_ack = out_port;
      tick();
      if (prev && !out_port) falls++;
    end
    out_ack = 1'b0;
  endtask

  initial begin
    int hi_cnt, falls, op;
    model_reset();
    out_ack = 1'b0;
    drive(2'd0, 1'b0, 1'b1, 32'd0);
    repeat (2) @(negedge clk);
    chk("rst_out_port", 32'(out_port), 32'd0);
    chk("rst_readdata", bus.readdata, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    reset_n = 1'b1;

    // Single doorbell with a delayed, two-cycle acknowledge.
    wr_tick(2'd0, 32'd1);
    tick();
    chk("t1_req_high", 32'(out_port), 32'd1);
    repeat (2) tick();
    out_ack = 1'b1;
    repeat (2) tick();
    out_ack = 1'b0;
    repeat (2) tick();
    rd_tick(2'd3);
    chk("t1_status", bus.readdata, 32'h1);
    wr_tick(2'd2, 32'h1);
    chk("t1_irq_on", 32'(irq), 32'd1);
    wr_tick(2'd3, 32'h1);
    chk("t1_irq_off", 32'(irq), 32'd0);

    // Timeout of 5 with a silent peer.
    wr_tick(2'd1, 32'd5);
    wr_tick(2'd0, 32'd1);
    hi_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_port) hi_cnt++;
    end
    chk("t2_high_cycles", 32'(hi_cnt), 32'd5);
    rd_tick(2'd3);
    chk("t2_status", bus.readdata, 32'h2);
    rd_tick(2'd0);
    chk("t2_busy", bus.readdata, 32'h0);
    wr_tick(2'd3, 32'h7);

    // Overflow: 17 writes against a stalled peer, then release it.
    wr_tick(2'd1, 32'd0);
    for (int i = 0; i < 17; i++) begin
      drive(2'd0, 1'b1, 1'b0, 32'd1);
      tick();
    end
    rd_tick(2'd0);
    chk("t3_pending", bus.readdata, 32'h0000_0F01);
    rd_tick(2'd3);
    chk("t3_ovf", bus.readdata & 32'h4, 32'h4);
    follow_peer(200, falls);
    chk("t3_handshakes", 32'(falls), 32'd16);
    wr_tick(2'd3, 32'h7);

    // Doorbell write coinciding with the IDLE to REQ dequeue.
    wr_tick(2'd0, 32'd1);
    wr_tick(2'd0, 32'd1);
    rd_tick(2'd0);
    chk("t4_pending", bus.readdata, 32'h0000_0101);
    follow_peer(40, falls);
    chk("t4_handshakes", 32'(falls), 32'd2);
    wr_tick(2'd3, 32'h7);

    // Done event and W1C of the same bit in one cycle.
    wr_tick(2'd0, 32'd1);
    tick();
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    wr_tick(2'd3, 32'h1);
    rd_tick(2'd3);
    chk("t5_done_kept", bus.readdata & 32'h1, 32'h1);
    wr_tick(2'd3, 32'h7);

    // Asynchronous reset while in REQ with three requests queued.
    for (int i = 0; i < 4; i++) wr_tick(2'd0, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("t6_out_port_async", 32'(out_port), 32'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    rd_tick(2'd0);
    chk("t6_pending", bus.readdata, 32'h0);
    rd_tick(2'd3);
    chk("t6_status", bus.readdata, 32'h0);
    rd_tick(2'd1);
    chk("t6_timeout", bus.readdata, 32'h0000_FFFF);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      op = int'($urandom_range(0, 99));
      if (op < 35)      drive(2'($urandom_range(0, 3)), 1'b0, 1'($urandom_range(0, 1)), $urandom);
      else if (op < 60) drive(2'd0, 1'b1, 1'b0, $urandom);
      else if (op < 75) drive(2'($urandom_range(0, 3)), 1'b1, 1'b1, $urandom);
      else if (op < 85) drive(2'd3, 1'b1, 1'b0, $urandom);
      else if (op < 92) drive(2'd2, 1'b1, 1'b0, $urandom);
      else              drive(2'd1, 1'b1, 1'b0, {$urandom_range(0, 65535) >= 32768 ? 16'hFFFF : 16'h0, 16'($urandom_range(0, 12))});
      if ($urandom_range(0, 3) == 0) out_ack = ~out_ack;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
